// File: rtl/linked_list_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : linked_list_drain_if
// Purpose  : Bundles the control, LL RAM read, packet-release, emptylist-free
//            and result signals of linked_list_drain.
// Ports    : slave modport  -> used by the drain block
//            master modport -> used by the flow controller / environment
// Entry layout of ll_rd_data, MSB first:
//            valid(1) last(1) seq(32) len(16) next(LL_AWIDTH)
//            pktID(PKT_AWIDTH) flits(5) last_7_bytes(56)
// Revision : 1.0  initial release
// ============================================================================
interface linked_list_drain_if #(
    parameter int LL_AWIDTH  = 10,
    parameter int PKT_AWIDTH = 12
);
    localparam int c_ENTRY_W = 2 + 32 + 16 + LL_AWIDTH + PKT_AWIDTH + 5 + 56;

    logic                   start;
    logic [LL_AWIDTH-1:0]   head_ptr;
    logic [31:0]            exp_seq;
    logic                   busy;
    logic                   ll_rd;
    logic [LL_AWIDTH-1:0]   ll_rd_addr;
    logic [c_ENTRY_W-1:0]   ll_rd_data;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [PKT_AWIDTH-1:0]  pkt_id;
    logic [4:0]             pkt_flits;
    logic [55:0]            pkt_last7;
    logic                   free_valid;
    logic                   free_ready;
    logic [LL_AWIDTH-1:0]   free_addr;
    logic                   done;
    logic [LL_AWIDTH-1:0]   new_head;
    logic                   list_empty;
    logic [31:0]            new_seq;
    logic [4:0]             drain_cnt;

    modport slave (
        input  start, head_ptr, exp_seq, ll_rd_data, pkt_ready, free_ready,
        output busy, ll_rd, ll_rd_addr, pkt_valid, pkt_id, pkt_flits, pkt_last7,
               free_valid, free_addr, done, new_head, list_empty, new_seq, drain_cnt
    );

    modport master (
        output start, head_ptr, exp_seq, ll_rd_data, pkt_ready, free_ready,
        input  busy, ll_rd, ll_rd_addr, pkt_valid, pkt_id, pkt_flits, pkt_last7,
               free_valid, free_addr, done, new_head, list_empty, new_seq, drain_cnt
    );
endinterface
`default_nettype wire

// File: rtl/linked_list_drain.sv
`default_nettype none
// ============================================================================
// Module   : linked_list_drain
// Purpose  : Walks a flow's out-of-order linked list from its head, releasing
//            every in-sequence node: descriptor goes downstream, node address
//            goes back to the emptylist, expected seq advances. Stops at a
//            gap, an invalid entry, the tail, or after MAX_DRAIN nodes, then
//            reports new head / new seq to the flow table.
// Ports    : clk, rst_n (async active-low)
//            bus (linked_list_drain_if.slave): start/head_ptr/exp_seq/busy,
//            ll_rd/ll_rd_addr/ll_rd_data, pkt_* handshake, free_* handshake,
//            done/new_head/list_empty/new_seq/drain_cnt results
// Revision : 1.0  initial release
// ============================================================================
module linked_list_drain #(
    parameter int LL_AWIDTH  = 10,
    parameter int PKT_AWIDTH = 12,
    parameter int RD_LATENCY = 2,
    parameter int MAX_DRAIN  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    linked_list_drain_if.slave  bus
);
    localparam int c_L7_LSB    = 0;
    localparam int c_FLITS_LSB = 56;
    localparam int c_PKT_LSB   = 61;
    localparam int c_NEXT_LSB  = c_PKT_LSB + PKT_AWIDTH;
    localparam int c_LEN_LSB   = c_NEXT_LSB + LL_AWIDTH;
    localparam int c_SEQ_LSB   = c_LEN_LSB + 16;
    localparam int c_LAST_BIT  = c_SEQ_LSB + 32;
    localparam int c_VALID_BIT = c_LAST_BIT + 1;
    localparam int c_ENTRY_W   = c_VALID_BIT + 1;
    localparam logic [4:0] c_MAX_CNT = 5'(MAX_DRAIN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_CHECK   = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [LL_AWIDTH-1:0]    addr_q, addr_d;
    logic [31:0]             seq_q, seq_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [c_ENTRY_W-1:0]    entry_q, entry_d;
    logic                    pkt_vld_q, pkt_vld_d;
    logic                    free_vld_q, free_vld_d;
    logic [RD_LATENCY-1:0]   rd_pipe_q;
    logic [LL_AWIDTH-1:0]    new_head_q, new_head_d;
    logic                    list_empty_q, list_empty_d;
    logic [31:0]             new_seq_q, new_seq_d;
    logic [4:0]              drain_cnt_q, drain_cnt_d;

    logic                    w_ll_rd;
    logic [RD_LATENCY:0]     w_rd_shift;
    logic                    w_rd_fire;
    logic                    w_e_valid;
    logic                    w_e_last;
    logic [31:0]             w_e_seq;
    logic [15:0]             w_e_len;
    logic [LL_AWIDTH-1:0]    w_e_next;
    logic [31:0]             w_seq_adv;
    logic [4:0]              w_cnt_inc;

    assign w_e_valid = entry_q[c_VALID_BIT];
    assign w_e_last  = entry_q[c_LAST_BIT];
    assign w_e_seq   = entry_q[c_SEQ_LSB +: 32];
    assign w_e_len   = entry_q[c_LEN_LSB +: 16];
    assign w_e_next  = entry_q[c_NEXT_LSB +: LL_AWIDTH];
    assign w_seq_adv = seq_q + {16'd0, w_e_len};
    assign w_cnt_inc = cnt_q + 5'd1;

    // The read pulse is delayed by RD_LATENCY cycles so the capture lines up
    // with the RAM's q output regardless of the configured latency.
    assign w_ll_rd    = (state_q == S_RD_REQ);
    assign w_rd_shift = {rd_pipe_q, w_ll_rd};
    assign w_rd_fire  = rd_pipe_q[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            seq_q        <= '0;
            cnt_q        <= '0;
            entry_q      <= '0;
            pkt_vld_q    <= 1'b0;
            free_vld_q   <= 1'b0;
            rd_pipe_q    <= '0;
            new_head_q   <= '0;
            list_empty_q <= 1'b0;
            new_seq_q    <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
            entry_q      <= entry_d;
            pkt_vld_q    <= pkt_vld_d;
            free_vld_q   <= free_vld_d;
            rd_pipe_q    <= w_rd_shift[RD_LATENCY-1:0];
            new_head_q   <= new_head_d;
            list_empty_q <= list_empty_d;
            new_seq_q    <= new_seq_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        seq_d        = seq_q;
        cnt_d        = cnt_q;
        entry_d      = entry_q;
        pkt_vld_d    = pkt_vld_q;
        free_vld_d   = free_vld_q;
        new_head_d   = new_head_q;
        list_empty_d = list_empty_q;
        new_seq_d    = new_seq_q;
        drain_cnt_d  = drain_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.head_ptr;
                    seq_d   = bus.exp_seq;
                    cnt_d   = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_rd_fire) begin
                    entry_d = bus.ll_rd_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                new_head_d  = addr_q;
                new_seq_d   = seq_q;
                drain_cnt_d = cnt_q;
                if (!w_e_valid) begin
                    list_empty_d = 1'b1;
                    state_d      = S_DONE;
                end else if (w_e_seq != seq_q) begin
                    // Gap ahead or stale/overlapping node: leave it in place.
                    list_empty_d = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    pkt_vld_d  = 1'b1;
                    free_vld_d = 1'b1;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                // Each side drops independently once accepted; the node is
                // only retired after both have been seen low.
                if (pkt_vld_q && bus.pkt_ready) begin
                    pkt_vld_d = 1'b0;
                end
                if (free_vld_q && bus.free_ready) begin
                    free_vld_d = 1'b0;
                end
                if (!pkt_vld_q && !free_vld_q) begin
                    seq_d       = w_seq_adv;
                    cnt_d       = w_cnt_inc;
                    new_seq_d   = w_seq_adv;
                    drain_cnt_d = w_cnt_inc;
                    new_head_d  = w_e_next;
                    if (w_e_last) begin
                        list_empty_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (w_cnt_inc == c_MAX_CNT) begin
                        list_empty_d = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        addr_d  = w_e_next;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.ll_rd      = w_ll_rd;
    assign bus.ll_rd_addr = addr_q;
    assign bus.pkt_valid  = pkt_vld_q;
    assign bus.pkt_id     = entry_q[c_PKT_LSB +: PKT_AWIDTH];
    assign bus.pkt_flits  = entry_q[c_FLITS_LSB +: 5];
    assign bus.pkt_last7  = entry_q[c_L7_LSB +: 56];
    assign bus.free_valid = free_vld_q;
    assign bus.free_addr  = addr_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.new_head   = new_head_q;
    assign bus.list_empty = list_empty_q;
    assign bus.new_seq    = new_seq_q;
    assign bus.drain_cnt  = drain_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_linked_list_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_linked_list_drain
// Purpose  : Directed scenarios for linked_list_drain against a RAM model with
//            scoreboard queues for released packets, freed nodes and results.
// Revision : 1.0  initial release
// ============================================================================
module tb_linked_list_drain;
    localparam int LLA  = 10;
    localparam int PKA  = 12;
    localparam int RL   = 2;
    localparam int MAXD = 16;
    localparam int EW   = 2 + 32 + 16 + LLA + PKA + 5 + 56;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linked_list_drain_if #(.LL_AWIDTH(LLA), .PKT_AWIDTH(PKA)) bus ();

    linked_list_drain #(
        .LL_AWIDTH(LLA), .PKT_AWIDTH(PKA), .RD_LATENCY(RL), .MAX_DRAIN(MAXD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // LL RAM model: q is the addressed entry RL cycles after the read request.
    logic [EW-1:0]  mem [0:(1<<LLA)-1];
    logic [LLA-1:0] ra  [RL];
    always @(posedge clk) begin
        ra[0] <= bus.ll_rd_addr;
        for (int i = 1; i < RL; i++) ra[i] <= ra[i-1];
    end
    assign bus.ll_rd_data = mem[ra[RL-1]];

    typedef struct packed {
        logic [PKA-1:0] id;
        logic [4:0]     fl;
        logic [55:0]    l7;
    } pkt_t;

    typedef struct {
        logic [LLA-1:0] head;
        bit             chk_head;
        bit             empty;
        logic [31:0]    seq;
        logic [4:0]     cnt;
        bit             chk_lat;
        int             start_cyc;
    } done_t;

    pkt_t           pkt_q  [$];
    logic [LLA-1:0] free_q [$];
    done_t          done_q [$];

    int vectors  = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_seen = 0;
    int exp_done = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic pkt_t desc_of(input logic [LLA-1:0] a, input logic [31:0] s, input logic [15:0] l);
        pkt_t p;
        p.id = PKA'(a) ^ 12'hA50;
        p.fl = 5'(a + 3);
        p.l7 = {s, 8'h5C, l};
        return p;
    endfunction

    task automatic add_node(input logic [LLA-1:0] a, input bit v, input bit last,
                            input logic [31:0] s, input logic [15:0] l,
                            input logic [LLA-1:0] nxt, input bit expect_rel);
        pkt_t p;
        p = desc_of(a, s, l);
        mem[a] = {v, last, s, l, nxt, p.id, p.fl, p.l7};
        if (expect_rel) begin
            pkt_q.push_back(p);
            free_q.push_back(a);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic start_drain(input logic [LLA-1:0] h, input logic [31:0] s, input done_t e);
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        done_q.push_back(e);
        exp_done++;
        bus.start    = 1'b1;
        bus.head_ptr = h;
        bus.exp_seq  = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_seen < exp_done && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_seen < exp_done) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got %0d done pulses required %0d", done_seen, exp_done);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_pkt_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.pkt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pkt_valid) begin
            vectors++;
            errors++;
            $display("FAIL pkt_valid_timeout: got 0 required 1");
        end
    endtask

    function automatic done_t mk_done(input logic [LLA-1:0] h, input bit ch, input bit em,
                                      input logic [31:0] s, input logic [4:0] c, input bit lat);
        done_t d;
        d.head = h; d.chk_head = ch; d.empty = em; d.seq = s; d.cnt = c;
        d.chk_lat = lat; d.start_cyc = 0;
        return d;
    endfunction

    // Monitor: packet and free handshakes, field stability, done results.
    bit          prev_pv = 1'b0;
    bit          prev_pr = 1'b0;
    logic [PKA+60:0] prev_pf = '0;
    initial forever begin
        pkt_t           ep;
        logic [LLA-1:0] ef;
        done_t          ed;
        bit             ok;
        @(negedge clk);
        if (!rst_n) begin
            prev_pv = 1'b0;
        end else begin
            if (bus.pkt_valid) begin
                if (prev_pv && !prev_pr) begin
                    vectors++;
                    if ({bus.pkt_id, bus.pkt_flits, bus.pkt_last7} !== prev_pf) begin
                        errors++;
                        $display("FAIL pkt_stable: got 0x%0h required 0x%0h",
                                 {bus.pkt_id, bus.pkt_flits, bus.pkt_last7}, prev_pf);
                    end
                end
                if (bus.pkt_ready) begin
                    vectors++;
                    if (pkt_q.size() == 0) begin
                        errors++;
                        $display("FAIL pkt_unexpected: got id 0x%0h required none", bus.pkt_id);
                    end else begin
                        ep = pkt_q.pop_front();
                        if (bus.pkt_id !== ep.id || bus.pkt_flits !== ep.fl || bus.pkt_last7 !== ep.l7) begin
                            errors++;
                            $display("FAIL pkt_desc: got %0h/%0h/%0h required %0h/%0h/%0h",
                                     bus.pkt_id, bus.pkt_flits, bus.pkt_last7, ep.id, ep.fl, ep.l7);
                        end
                    end
                end
            end
            prev_pv = bus.pkt_valid;
            prev_pr = bus.pkt_ready;
            prev_pf = {bus.pkt_id, bus.pkt_flits, bus.pkt_last7};

            if (bus.free_valid && bus.free_ready) begin
                vectors++;
                if (free_q.size() == 0) begin
                    errors++;
                    $display("FAIL free_unexpected: got addr %0d required none", bus.free_addr);
                end else begin
                    ef = free_q.pop_front();
                    if (bus.free_addr !== ef) begin
                        errors++;
                        $display("FAIL free_addr: got %0d required %0d", bus.free_addr, ef);
                    end
                end
            end

            if (bus.done) begin
                done_seen++;
                vectors++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done required none");
                end else begin
                    ed = done_q.pop_front();
                    ok = (bus.list_empty === ed.empty) && (bus.new_seq === ed.seq) &&
                         (bus.drain_cnt === ed.cnt) &&
                         (!ed.chk_head || bus.new_head === ed.head) &&
                         (!ed.chk_lat || cyc == ed.start_cyc + RL + 3);
                    if (!ok) begin
                        errors++;
                        $display("FAIL done_result: got head=%0d empty=%0d seq=0x%0h cnt=%0d cyc=%0d required head=%0d empty=%0d seq=0x%0h cnt=%0d cyc=%0d",
                                 bus.new_head, bus.list_empty, bus.new_seq, bus.drain_cnt, cyc,
                                 ed.head, ed.empty, ed.seq, ed.cnt, ed.start_cyc + RL + 3);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_done"},       64'(bus.done),       64'd0);
        chk({tag, "_pkt_valid"},  64'(bus.pkt_valid),  64'd0);
        chk({tag, "_free_valid"}, 64'(bus.free_valid), 64'd0);
        chk({tag, "_ll_rd"},      64'(bus.ll_rd),      64'd0);
        chk({tag, "_new_seq"},    64'(bus.new_seq),    64'd0);
        chk({tag, "_drain_cnt"},  64'(bus.drain_cnt),  64'd0);
        chk({tag, "_pkt_id"},     64'(bus.pkt_id),     64'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << LLA); i++) mem[i] = '0;
        bus.start      = 1'b0;
        bus.head_ptr   = '0;
        bus.exp_seq    = '0;
        bus.pkt_ready  = 1'b1;
        bus.free_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Empty list: head entry invalid, fixed done latency
        add_node(3, 1'b0, 1'b0, 32'd0, 16'd0, 10'd0, 1'b0);
        start_drain(3, 32'd100, mk_done(0, 1'b0, 1'b1, 32'd100, 5'd0, 1'b1));
        wait_done();

        // Three-node chain to tail; a second start while busy is ignored
        add_node(5, 1'b1, 1'b0, 32'd100, 16'd10, 10'd9, 1'b1);
        add_node(9, 1'b1, 1'b0, 32'd110, 16'd20, 10'd2, 1'b1);
        add_node(2, 1'b1, 1'b1, 32'd130, 16'd5,  10'd0, 1'b1);
        start_drain(5, 32'd100, mk_done(0, 1'b0, 1'b1, 32'd135, 5'd3, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.head_ptr = 10'd3; bus.exp_seq = 32'd777;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();

        // Gap after the first node
        add_node(5, 1'b1, 1'b0, 32'd100, 16'd10, 10'd9, 1'b1);
        add_node(9, 1'b1, 1'b0, 32'd150, 16'd10, 10'd0, 1'b0);
        start_drain(5, 32'd100, mk_done(9, 1'b1, 1'b0, 32'd110, 5'd1, 1'b0));
        wait_done();

        // Packet backpressure with the free side always ready
        add_node(7, 1'b1, 1'b1, 32'd500, 16'd4, 10'd0, 1'b1);
        bus.pkt_ready = 1'b0;
        start_drain(7, 32'd500, mk_done(0, 1'b0, 1'b1, 32'd504, 5'd1, 1'b0));
        wait_pkt_valid();
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_done_yet", 64'(done_seen), 64'(exp_done - 1));
        chk("bp_busy",        64'(bus.busy),  64'd1);
        bus.pkt_ready = 1'b1;
        wait_done();

        // Expected seq wraps past 2^32
        add_node(8, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'd16, 10'd0, 1'b1);
        start_drain(8, 32'hFFFF_FFF8, mk_done(0, 1'b0, 1'b1, 32'h0000_0008, 5'd1, 1'b0));
        wait_done();

        // Stale head (seq below expected) is left in place
        add_node(11, 1'b1, 1'b0, 32'd90, 16'd10, 10'd0, 1'b0);
        start_drain(11, 32'd100, mk_done(11, 1'b1, 1'b0, 32'd100, 5'd0, 1'b0));
        wait_done();

        // 17 in-order nodes: only MAX_DRAIN are released
        for (int i = 0; i < 17; i++)
            add_node(LLA'(20 + i), 1'b1, 1'b0, 32'(1000 + i), 16'd1, LLA'(21 + i), (i < MAXD));
        start_drain(20, 32'd1000, mk_done(36, 1'b1, 1'b0, 32'd1016, 5'd16, 1'b0));
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_new_seq",   64'(bus.new_seq),   64'd1016);
        chk("hold_drain_cnt", 64'(bus.drain_cnt), 64'd16);
        chk("hold_new_head",  64'(bus.new_head),  64'd36);

        // Asynchronous reset while a descriptor is pending
        add_node(12, 1'b1, 1'b1, 32'd200, 16'd3, 10'd0, 1'b1);
        bus.pkt_ready  = 1'b0;
        bus.free_ready = 1'b0;
        start_drain(12, 32'd200, mk_done(0, 1'b0, 1'b1, 32'd203, 5'd1, 1'b0));
        wait_pkt_valid();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        pkt_q.delete();
        free_q.delete();
        done_q.delete();
        exp_done--;
        bus.pkt_ready  = 1'b1;
        bus.free_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_node(12, 1'b1, 1'b1, 32'd200, 16'd3, 10'd0, 1'b1);
        start_drain(12, 32'd200, mk_done(0, 1'b0, 1'b1, 32'd203, 5'd1, 1'b0));
        wait_done();

        chk("left_pkts",  64'(pkt_q.size()),  64'd0);
        chk("left_frees", 64'(free_q.size()), 64'd0);
        chk("left_dones", 64'(done_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
